reg_file_scoreboard: RTL and testbench

- Multi-entry register file for the project3 datapath: one write (writeback) port, two combinational read ports.
- Each entry carries a busy bit marking a pending write, so the decode stage can see which source operands are not yet valid.
- Sits between decode (reads, issue) and writeback (writes); built from the same signed-register storage semantics the datapath already uses.

---
 rtl/reg_file_scoreboard.sv | 135 +++++++++++++
 tb/tb_reg_file_scoreboard.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_scoreboard.sv
// Register file with per-entry busy (pending-write) tracking.
//
// One writeback port and two combinational read ports. Each register has a busy
// bit set by issue and cleared by writeback, so decode can tell which source
// operands are not yet valid. Reads bypass a same-cycle writeback for both data
// and busy.
//
// Ports:
//   clk, reset_n            rising-edge clock, asynchronous active-low reset
//   rd_addr_a/b             read addresses
//   rd_data_a/b             read data (signed), zero for out-of-range addresses
//   busy_a/b                pending-write flag of the addressed register
//   wr_en/wr_addr/wr_data   writeback port; also clears the busy bit
//   issue_en/issue_addr     marks a destination register busy
//   busy_count              registered population count of the busy bits
module reg_file_scoreboard #(
    parameter int unsigned          BIT_WIDTH   = 32,
    parameter int unsigned          REG_COUNT   = 16,
    parameter int unsigned          ADDR_WIDTH  = 4,
    parameter logic [BIT_WIDTH-1:0] RESET_VALUE = '0,
    parameter bit                   ZERO_REG    = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [ADDR_WIDTH-1:0]       rd_addr_a,
    input  logic [ADDR_WIDTH-1:0]       rd_addr_b,
    output logic signed [BIT_WIDTH-1:0] rd_data_a,
    output logic signed [BIT_WIDTH-1:0] rd_data_b,
    output logic                        busy_a,
    output logic                        busy_b,
    input  logic                        wr_en,
    input  logic [ADDR_WIDTH-1:0]       wr_addr,
    input  logic [BIT_WIDTH-1:0]        wr_data,
    input  logic                        issue_en,
    input  logic [ADDR_WIDTH-1:0]       issue_addr,
    output logic [ADDR_WIDTH:0]         busy_count
);

    logic [BIT_WIDTH-1:0]  r_regs [REG_COUNT];
    logic [REG_COUNT-1:0]  r_busy;
    logic [ADDR_WIDTH:0]   r_busy_count;

    logic [REG_COUNT-1:0]  w_busy_d;
    logic [ADDR_WIDTH:0]   w_count_d;
    logic                  w_wr_ok;
    logic                  w_issue_ok;

    logic [ADDR_WIDTH-1:0] w_rd_addr [2];
    logic [BIT_WIDTH-1:0]  w_rd_data [2];
    logic                  w_rd_busy [2];

    // An address is writable when it names a real register that is not the
    // hardwired zero register.
    function automatic logic writable(input logic [ADDR_WIDTH-1:0] addr);
        return (32'(addr) < REG_COUNT) && !(ZERO_REG && (addr == '0));
    endfunction

    assign w_wr_ok    = wr_en && writable(wr_addr);
    assign w_issue_ok = issue_en && writable(issue_addr);

    // Next busy vector: writeback clears, issue sets afterwards so that an issue
    // to the same destination on the same edge leaves the register busy.
    always_comb begin
        w_busy_d  = r_busy;
        w_count_d = '0;
        for (int unsigned i = 0; i < REG_COUNT; i++) begin
            if (w_wr_ok && (32'(wr_addr) == i)) begin
                w_busy_d[i] = 1'b0;
            end
            if (w_issue_ok && (32'(issue_addr) == i)) begin
                w_busy_d[i] = 1'b1;
            end
        end
        for (int unsigned i = 0; i < REG_COUNT; i++) begin
            w_count_d = w_count_d + (ADDR_WIDTH + 1)'(w_busy_d[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy       <= '0;
            r_busy_count <= '0;
        end else begin
            r_busy       <= w_busy_d;
            r_busy_count <= w_count_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= (ZERO_REG && (i == 0)) ? '0 : RESET_VALUE;
            end
        end else begin
            for (int unsigned i = 0; i < REG_COUNT; i++) begin
                if (w_wr_ok && (32'(wr_addr) == i)) begin
                    r_regs[i] <= wr_data;
                end
            end
        end
    end

    assign w_rd_addr[0] = rd_addr_a;
    assign w_rd_addr[1] = rd_addr_b;

    // Read ports: array lookup (zero when out of range), then writeback bypass,
    // then the hardwired zero register overrides everything.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rd_data[p] = '0;
            w_rd_busy[p] = 1'b0;
            for (int unsigned i = 0; i < REG_COUNT; i++) begin
                if (32'(w_rd_addr[p]) == i) begin
                    w_rd_data[p] = r_regs[i];
                    w_rd_busy[p] = r_busy[i];
                end
            end
            if (w_wr_ok && (wr_addr == w_rd_addr[p])) begin
                w_rd_data[p] = wr_data;
                w_rd_busy[p] = 1'b0;
            end
            if (ZERO_REG && (w_rd_addr[p] == '0)) begin
                w_rd_data[p] = '0;
                w_rd_busy[p] = 1'b0;
            end
        end
    end

    assign rd_data_a  = w_rd_data[0];
    assign rd_data_b  = w_rd_data[1];
    assign busy_a     = w_rd_busy[0];
    assign busy_b     = w_rd_busy[1];
    assign busy_count = r_busy_count;

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Scoreboard bench for reg_file_scoreboard (built with ADDR_WIDTH=5 so that
// addresses 16..31 are out of range). The driver predicts each cycle's outputs
// from a plain array model and queues them; the monitor pops and compares on
// every falling edge.
module tb_reg_file_scoreboard;

    localparam int BW = 32;
    localparam int RC = 16;
    localparam int AW = 5;

    logic                 clk;
    logic                 reset_n;
    logic [AW-1:0]        rd_addr_a;
    logic [AW-1:0]        rd_addr_b;
    logic signed [BW-1:0] rd_data_a;
    logic signed [BW-1:0] rd_data_b;
    logic                 busy_a;
    logic                 busy_b;
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [BW-1:0]        wr_data;
    logic                 issue_en;
    logic [AW-1:0]        issue_addr;
    logic [AW:0]          busy_count;

    reg_file_scoreboard #(
        .BIT_WIDTH  (BW),
        .REG_COUNT  (RC),
        .ADDR_WIDTH (AW),
        .RESET_VALUE('0),
        .ZERO_REG   (1'b1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .busy_a    (busy_a),
        .busy_b    (busy_b),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .issue_en  (issue_en),
        .issue_addr(issue_addr),
        .busy_count(busy_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [BW-1:0] da;
        logic          ba;
        logic [BW-1:0] db;
        logic          bb;
        logic [AW:0]   cnt;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: architectural register contents and pending-write set.
    logic [BW-1:0] m_regs [RC];
    bit            m_busy [RC];

    function automatic bit legal(input int a);
        return (a > 0) && (a < RC);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < RC; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endfunction

    function automatic void read_model(input int a, output logic [BW-1:0] d, output logic b);
        bool_bypass: begin
            d = '0;
            b = 1'b0;
            if (legal(a)) begin
                if (wr_en && int'(wr_addr) == a) begin
                    d = wr_data;
                end else begin
                    d = m_regs[a];
                    b = m_busy[a];
                end
            end
        end
    endfunction

    function automatic exp_t predict();
        exp_t e;
        int   n = 0;
        read_model(int'(rd_addr_a), e.da, e.ba);
        read_model(int'(rd_addr_b), e.db, e.bb);
        for (int i = 0; i < RC; i++) n += int'(m_busy[i]);
        e.cnt = (AW + 1)'(n);
        return e;
    endfunction

    // Architectural effect of the edge just taken with the held inputs.
    function automatic void commit();
        if (wr_en && legal(int'(wr_addr))) begin
            m_regs[int'(wr_addr)] = wr_data;
            m_busy[int'(wr_addr)] = 1'b0;
        end
        if (issue_en && legal(int'(issue_addr))) begin
            m_busy[int'(issue_addr)] = 1'b1;
        end
    endfunction

    // Called at posedge+1; returns at the next posedge+1.
    task automatic step(input logic we, input int wa, input logic [BW-1:0] wd,
                        input logic ie, input int ia, input int ra, input int rb);
        wr_en      = we;
        wr_addr    = AW'(wa);
        wr_data    = wd;
        issue_en   = ie;
        issue_addr = AW'(ia);
        rd_addr_a  = AW'(ra);
        rd_addr_b  = AW'(rb);
        q.push_back(predict());
        @(posedge clk);
        commit();
        #1;
    endtask

    // Asserts reset between edges; the monitor samples before any clock edge.
    task automatic async_reset_step(input int ra);
        wr_en     = 1'b0;
        issue_en  = 1'b0;
        rd_addr_a = AW'(ra);
        rd_addr_b = AW'(ra);
        #1 reset_n = 1'b0;
        model_reset();
        q.push_back(predict());
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic idle(input int ra, input int rb);
        step(1'b0, 0, '0, 1'b0, 0, ra, rb);
    endtask

    function automatic void check(input string name, input logic [BW-1:0] act,
                                  input logic [BW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
        end
    endfunction

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("rd_data_a", rd_data_a, e.da);
            check("busy_a", BW'(busy_a), BW'(e.ba));
            check("rd_data_b", rd_data_b, e.db);
            check("busy_b", BW'(busy_b), BW'(e.bb));
            check("busy_count", BW'(busy_count), BW'(e.cnt));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n    = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        issue_en   = 1'b0;
        issue_addr = '0;
        rd_addr_a  = '0;
        rd_addr_b  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Reset state across every address, including out-of-range ones.
        for (int a = 0; a < 32; a++) idle(a, 31 - a);

        // Mid-run asynchronous reset clears reg5 without a clock edge.
        step(1'b1, 5, 32'h1234, 1'b0, 0, 5, 5);
        idle(5, 5);
        async_reset_step(5);
        idle(5, 5);

        // Write bypass, then the stored value.
        step(1'b1, 3, 32'hDEADBEEF, 1'b0, 0, 3, 0);
        idle(3, 3);

        // Issue then writeback; the writeback cycle un-busies and bypasses.
        step(1'b0, 0, '0, 1'b1, 7, 7, 7);
        idle(7, 7);
        step(1'b1, 7, 32'd42, 1'b0, 0, 7, 7);
        idle(7, 7);

        // Issue and writeback to the same register on one edge: newer issue wins.
        step(1'b1, 7, 32'd5, 1'b1, 7, 7, 7);
        idle(7, 7);
        step(1'b1, 7, 32'd5, 1'b0, 0, 7, 3);
        idle(7, 7);

        // Register 0 is hardwired.
        step(1'b1, 0, 32'hFFFFFFFF, 1'b1, 0, 0, 0);
        idle(0, 0);

        // Fill every busy bit, then drain in reverse order.
        for (int r = 1; r < RC; r++) step(1'b0, 0, '0, 1'b1, r, r, 0);
        idle(15, 1);
        for (int r = RC - 1; r > 0; r--) step(1'b1, r, BW'(r * 3 + 100), 1'b0, 0, r, r - 1);
        idle(1, 15);

        // Out-of-range write and issue are ignored.
        step(1'b1, 16, 32'hAAAA, 1'b1, 20, 16, 31);
        idle(16, 20);

        // Randomised traffic.
        for (int n = 0; n < 600; n++) begin
            int wa, ia, ra, rb;
            logic [BW-1:0] wd;
            wa = ($urandom_range(0, 9) == 0) ? int'($urandom_range(16, 31))
                                             : int'($urandom_range(0, 15));
            ia = ($urandom_range(0, 9) == 0) ? int'($urandom_range(16, 31))
                                             : int'($urandom_range(0, 15));
            ra = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, 17));
            rb = ($urandom_range(0, 3) == 0) ? ra : int'($urandom_range(0, 17));
            wd = $urandom;
            step(logic'($urandom_range(0, 1)), wa, wd, logic'($urandom_range(0, 2) != 0),
                 ia, ra, rb);
        end

        @(negedge clk);
        #1;
        check("queue_drained", BW'(q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
